// File: rtl/complex_pkg.sv
// Shared helpers for the packed {re, im} complex word used by the multiplier and the integrate-and-dump.
// Helpers work on a 64-bit container so one set serves any WIDTH up to CPX_MAX_WIDTH.
package complex_pkg;

  localparam int unsigned CPX_MAX_WIDTH = 64;
  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_LOG_N = 4;

  typedef logic [CPX_MAX_WIDTH-1:0]   cpx_word_t;
  typedef logic [CPX_MAX_WIDTH/2-1:0] cpx_half_t;

  // Ones in the low WIDTH/2 bits: selects one component of a packed word.
  function automatic cpx_word_t cpx_half_mask(input int unsigned width);
    return (cpx_word_t'(1) << (width / 2)) - cpx_word_t'(1);
  endfunction

  function automatic cpx_half_t cpx_re(input cpx_word_t word, input int unsigned width);
    return cpx_half_t'((word >> (width / 2)) & cpx_half_mask(width));
  endfunction

  function automatic cpx_half_t cpx_im(input cpx_word_t word, input int unsigned width);
    return cpx_half_t'(word & cpx_half_mask(width));
  endfunction

  function automatic cpx_word_t cpx_pack(input cpx_half_t re, input cpx_half_t im,
                                         input int unsigned width);
    return ((cpx_word_t'(re) & cpx_half_mask(width)) << (width / 2))
         | (cpx_word_t'(im) & cpx_half_mask(width));
  endfunction

endpackage

// File: rtl/complex_component_acc.sv
// One signed component accumulator; avg is the combinational (acc + sample) >>> LOG_N used at dump.
// Accumulator is IN_W+LOG_N bits wide so 2**LOG_N samples can never overflow it.
module complex_component_acc #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned LOG_N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   add,
  input  logic                   dump,
  input  logic signed [IN_W-1:0] sample,
  output logic signed [IN_W-1:0] avg
);

  localparam int unsigned ACC_W = IN_W + LOG_N;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign sum = acc + ACC_W'(sample);
  // Dropping the low LOG_N bits is an arithmetic shift with floor truncation.
  assign avg = sum[ACC_W-1:LOG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear || dump) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/complex_integrate_dump.sv
// Integrate 2**LOG_N complex samples and emit the block average; result valid one cycle after the last accept.
// Only the dump-causing sample is held off while an unconsumed result is stalled downstream.
module complex_integrate_dump
  import complex_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LOG_N = DEFAULT_LOG_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam logic [LOG_N-1:0] LAST = '1;

  logic [LOG_N-1:0]       count;
  logic                   full;
  logic                   accept;
  logic                   dump;
  cpx_word_t              in_word;
  cpx_word_t              dump_word;
  logic signed [HALF-1:0] s_re;
  logic signed [HALF-1:0] s_im;
  logic signed [HALF-1:0] avg_re;
  logic signed [HALF-1:0] avg_im;

  assign full     = (count == LAST);
  assign in_ready = rst_n & ~clear & ~(out_valid & ~out_ready & full);
  assign accept   = in_valid & in_ready;
  assign dump     = accept & full;

  assign in_word = cpx_word_t'(in_data);
  assign s_re    = HALF'(cpx_re(in_word, WIDTH));
  assign s_im    = HALF'(cpx_im(in_word, WIDTH));

  complex_component_acc #(
    .IN_W  (HALF),
    .LOG_N (LOG_N)
  ) u_acc_re (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .add    (accept & ~full),
    .dump   (dump),
    .sample (s_re),
    .avg    (avg_re)
  );

  complex_component_acc #(
    .IN_W  (HALF),
    .LOG_N (LOG_N)
  ) u_acc_im (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .add    (accept & ~full),
    .dump   (dump),
    .sample (s_im),
    .avg    (avg_im)
  );

  assign dump_word = cpx_pack(cpx_half_t'(avg_re), cpx_half_t'(avg_im), WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      // The counter wraps to zero on the dump accept by itself.
      if (clear) begin
        count <= '0;
      end else if (accept) begin
        count <= count + LOG_N'(1);
      end

      // A dump on the same edge as a consume replaces the result and keeps valid high.
      if (dump) begin
        out_data  <= WIDTH'(dump_word);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_complex_integrate_dump.sv
// Directed bench for complex_integrate_dump with WIDTH=32, LOG_N=2 (4-sample blocks).
module tb_complex_integrate_dump;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  complex_integrate_dump #(.WIDTH(32), .LOG_N(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one sample and hold it until accepted (bounded); returns one cycle after the accept edge.
  task automatic send(input logic [15:0] re, input logic [15:0] im);
    int w;
    in_data  = {re, im};
    in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h required 00000000", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    @(posedge clk); @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) send(16'd100, 16'hFFF8);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
    send(16'd100, 16'hFFF8);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b required 1", out_valid); end
    n_cmp++; if (out_data !== 32'h0064FFF8) begin n_err++; $display("FAIL basic_data: got %h required 0064fff8", out_data); end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed: got %b required 0", out_valid); end
  endtask

  task automatic test_truncation();
    send(16'hFFFF, 16'h0001);
    for (int k = 0; k < 3; k++) send(16'h0000, 16'h0000);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL trunc_valid: got %b required 1", out_valid); end
    n_cmp++; if (out_data !== 32'hFFFF0000) begin n_err++; $display("FAIL trunc_data: got %h required ffff0000", out_data); end
    consume();
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 4; k++) send(16'h8000, 16'h7FFF);
    n_cmp++; if (out_data !== 32'h80007FFF) begin n_err++; $display("FAIL extreme_data: got %h required 80007fff", out_data); end
    consume();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[8];
    logic [31:0] d;
    logic        v, r, acc_now, pulse_cycle;
    int          i, nout, cyc, phase, b;
    for (int k = 0; k < 8; k++) exp_q[k] = {16'(k * 100 + 1), 16'(-(2 * (k + 1)))};
    i = 0; nout = 0; cyc = 0; phase = 0;
    while (nout < 8 && cyc < 400) begin
      b = i / 4;
      in_valid = (i < 32);
      in_data  = {16'(b * 100 + (i % 4)), 16'(-(2 * (b + 1)))};
      pulse_cycle = 1'b0;
      if (phase == 0) out_ready = 1'b0;
      else if (phase == 1) begin out_ready = 1'b1; pulse_cycle = 1'b1; phase = 2; end
      else out_ready = (cyc % 3 != 0);
      #1;
      if (phase == 0 && in_valid && !in_ready) begin
        phase = 1;
        n_cmp++; if (i != 7) begin n_err++; $display("FAIL bp_stall_index: got %0d required 7", i); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
          n_err++; $display("FAIL bp_pending: got %b/%h required 1/%h", out_valid, out_data, exp_q[0]);
        end
      end
      if (pulse_cycle) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_pulse_ready: got %b required 1", in_ready); end
      end
      acc_now = in_valid & in_ready; v = out_valid; d = out_data; r = out_ready;
      @(posedge clk); #1;
      if (acc_now) i++;
      if (v && r) begin
        n_cmp++; if (d !== exp_q[nout]) begin n_err++; $display("FAIL bp_result%0d: got %h required %h", nout, d, exp_q[nout]); end
        nout++;
      end
      if (pulse_cycle) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[1]) begin
          n_err++; $display("FAIL bp_consume_dump: got %b/%h required 1/%h", out_valid, out_data, exp_q[1]);
        end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (nout != 8 || i != 32) begin n_err++; $display("FAIL bp_totals: got %0d results %0d samples required 8 and 32", nout, i); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b required 0", out_valid); end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 4; k++) send(16'd8, 16'd0);
    send(16'd1000, 16'd0);
    send(16'd1000, 16'd0);
    clear = 1'b1; in_valid = 1'b1; in_data = {16'd1000, 16'd0};
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clear_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00080000) begin
      n_err++; $display("FAIL clear_pending: got %b/%h required 1/00080000", out_valid, out_data);
    end
    consume();
    for (int k = 0; k < 3; k++) send(16'd4, 16'd0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_early_valid: got %b required 0", out_valid); end
    send(16'd4, 16'd0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00040000) begin
      n_err++; $display("FAIL clear_result: got %b/%h required 1/00040000", out_valid, out_data);
    end
    consume();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) send(16'd20, 16'd0);
    for (int k = 0; k < 3; k++) send(16'd500, 16'd0);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b required 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL arst_data: got %h required 00000000", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(16'hFFFA, 16'd10);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hFFFA000A) begin
      n_err++; $display("FAIL arst_fresh_block: got %b/%h required 1/fffa000a", out_valid, out_data);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_extremes();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
